uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo_pkg.sv | 28 ++
 rtl/uart_tx_fifo_if.sv | 34 +++
 rtl/uart_tx_fifo_sync_fifo.sv | 74 +++++++
 rtl/uart_tx_fifo.sv | 234 +++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared types and constants for the UART transmit path (and a future
//   receive path): transmitter FSM state encoding, parity mode codes and the
//   minimum number of data bits a frame may carry.
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Parity mode field; the code 2'b11 is also treated as "no parity".
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int MIN_DATA_BITS = 5;

  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_if
//   Push channel from a producer (CPU bridge / DMA) into the UART transmit
//   FIFO.
//
//   Handshake: a word transfers on every rising clk edge where i_tx_valid and
//   o_tx_ready are both high. o_tx_ready depends only on registered FIFO
//   state (never on i_tx_valid); the producer may raise i_tx_valid at any
//   time and must hold i_tx_data stable while i_tx_valid is high.
//
//   Signals:
//     i_tx_valid  producer -> uart  push request
//     i_tx_data   producer -> uart  push word, LSB transmitted first
//     o_tx_ready  uart -> producer  FIFO has room
// ---------------------------------------------------------------------------
interface uart_tx_fifo_if #(
  parameter int DATA_WIDTH = 9
);
  logic                  i_tx_valid;
  logic [DATA_WIDTH-1:0] i_tx_data;
  logic                  o_tx_ready;

  modport master (
    output i_tx_valid,
    output i_tx_data,
    input  o_tx_ready
  );

  modport slave (
    input  i_tx_valid,
    input  i_tx_data,
    output o_tx_ready
  );
endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with extra-MSB read/write pointers. Head word is
//   presented combinationally on pop_data_o; a pop consumes it.
//
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     push_i         write request (ignored while full, even with a pop)
//     push_data_i    write word
//     pop_i          read request (ignored while empty)
//     pop_data_o     current head word
//     level_o        number of stored words (0..FIFO_DEPTH)
//     empty_o        no words stored
//     full_o         FIFO_DEPTH words stored
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int DATA_WIDTH = 9,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push_i,
  input  logic [DATA_WIDTH-1:0]         push_data_i,
  input  logic                          pop_i,
  output logic [DATA_WIDTH-1:0]         pop_data_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          empty_o,
  output logic                          full_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic                  push_ok;
  logic                  pop_ok;

  // Same index with differing wrap bit means the writer is a full lap ahead.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;

  // Push gates on the registered full flag only, so a simultaneous pop
  // never frees room for a push in the same cycle.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   UART transmitter with a built-in transmit FIFO. Frame settings are
//   sampled when a word is popped and held for the whole frame; queued words
//   leave back-to-back with no idle bit between frames.
//
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     tx_if          push channel (slave side): i_tx_valid, i_tx_data,
//                    o_tx_ready (= ~o_fifo_full)
//     i_cfg_bits     data bits per frame, clamped to 5..DATA_WIDTH
//     i_cfg_parity   00 none, 01 even, 10 odd, 11 none
//     i_cfg_stop     0 = one stop bit, 1 = two
//     i_cfg_div      bit period is i_cfg_div+1 clocks
//     o_tx_serial    registered serial line, idle high
//     o_tx_busy      FSM not in IDLE
//     o_tx_done      one-cycle pulse as each frame's last stop bit ends
//     o_fifo_level   stored word count
//     o_fifo_empty   FIFO empty flag
//     o_fifo_full    FIFO full flag
//     o_state        current FSM state (debug)
// ---------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 9,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  uart_tx_fifo_if.slave                      tx_if,
  input  logic [$clog2(DATA_WIDTH+1)-1:0]    i_cfg_bits,
  input  logic [1:0]                         i_cfg_parity,
  input  logic                               i_cfg_stop,
  input  logic [DIV_WIDTH-1:0]               i_cfg_div,
  output logic                               o_tx_serial,
  output logic                               o_tx_busy,
  output logic                               o_tx_done,
  output logic [$clog2(FIFO_DEPTH):0]        o_fifo_level,
  output logic                               o_fifo_empty,
  output logic                               o_fifo_full,
  output uart_state_e                        o_state
);

  localparam int BW = $clog2(DATA_WIDTH+1);

  function automatic logic [BW-1:0] clamp_bits(input logic [BW-1:0] b);
    if (b < BW'(MIN_DATA_BITS)) return BW'(MIN_DATA_BITS);
    if (b > BW'(DATA_WIDTH))    return BW'(DATA_WIDTH);
    return b;
  endfunction

  // FIFO -----------------------------------------------------------------
  logic                  fifo_pop;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  fifo_empty;
  logic                  fifo_full;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (tx_if.i_tx_valid),
    .push_data_i (tx_if.i_tx_data),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_head),
    .level_o     (o_fifo_level),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  assign tx_if.o_tx_ready = ~fifo_full;
  assign o_fifo_empty     = fifo_empty;
  assign o_fifo_full      = fifo_full;

  // Transmitter state ------------------------------------------------------
  uart_state_e           state_q, state_d;
  logic [DIV_WIDTH-1:0]  baud_q, baud_d;
  logic [BW-1:0]         bit_q, bit_d;     // data bit index, or stop bit index
  logic [DATA_WIDTH-1:0] shift_q, shift_d; // bit 0 is the next data bit
  logic                  par_q, par_d;     // XOR of data bits sent so far
  logic                  serial_q, serial_d;
  logic                  done_q, done_d;

  // Frame settings captured at pop time.
  logic [BW-1:0]         bits_q, bits_d;
  logic [1:0]            parity_q, parity_d;
  logic                  stop_q, stop_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;

  logic                  bit_end;
  logic                  load_frame;

  assign bit_end = (baud_q == div_q);

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_d      = par_q;
    serial_d   = serial_q;
    done_d     = 1'b0;
    bits_d     = bits_q;
    parity_d   = parity_q;
    stop_d     = stop_q;
    div_d      = div_q;
    fifo_pop   = 1'b0;
    load_frame = 1'b0;

    // Baud counter runs for the whole frame and wraps at the latched divisor.
    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    // serial_d always carries the line level of the bit period being
    // entered, so the registered line lines up with state_q.
    case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        if (!fifo_empty) load_frame = 1'b1;
      end

      START: begin
        if (bit_end) begin
          state_d  = DATA;
          bit_d    = '0;
          serial_d = shift_q[0];
        end
      end

      DATA: begin
        if (bit_end) begin
          par_d = par_q ^ shift_q[0];
          if (bit_q == bits_q - BW'(1)) begin
            bit_d = '0;
            if (parity_enabled(parity_q)) begin
              state_d  = PARITY;
              serial_d = (par_q ^ shift_q[0]) ^ (parity_q == PAR_ODD);
            end else begin
              state_d  = STOP;
              serial_d = 1'b1;
            end
          end else begin
            bit_d    = bit_q + 1'b1;
            shift_d  = shift_q >> 1;
            serial_d = shift_q[1];
          end
        end
      end

      PARITY: begin
        if (bit_end) begin
          state_d  = STOP;
          bit_d    = '0;
          serial_d = 1'b1;
        end
      end

      STOP: begin
        if (bit_end) begin
          if (bit_q == BW'(stop_q)) begin
            done_d = 1'b1;
            if (!fifo_empty) begin
              load_frame = 1'b1;
            end else begin
              state_d  = IDLE;
              serial_d = 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

      default: begin
        state_d  = IDLE;
        serial_d = 1'b1;
      end
    endcase

    // Frame start from IDLE or straight out of the last stop bit.
    if (load_frame) begin
      fifo_pop = 1'b1;
      state_d  = START;
      serial_d = 1'b0;
      baud_d   = '0;
      bit_d    = '0;
      par_d    = 1'b0;
      shift_d  = fifo_head;
      bits_d   = clamp_bits(i_cfg_bits);
      parity_d = i_cfg_parity;
      stop_d   = i_cfg_stop;
      div_d    = i_cfg_div;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      serial_q <= 1'b1;
      done_q   <= 1'b0;
      bits_q   <= '0;
      parity_q <= PAR_NONE;
      stop_q   <= 1'b0;
      div_q    <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      serial_q <= serial_d;
      done_q   <= done_d;
      bits_q   <= bits_d;
      parity_q <= parity_d;
      stop_q   <= stop_d;
      div_q    <= div_d;
    end
  end

  assign o_tx_serial = serial_q;
  assign o_tx_busy   = (state_q != IDLE);
  assign o_tx_done   = done_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Directed and randomized scenarios for uart_tx_fifo. A recorder samples
//   {busy, done, serial} on every falling edge; a reference model builds the
//   expected per-cycle stream from the frame rules (start, LSB-first data,
//   optional parity, stop bits, each held div+1 clocks).
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DW    = 9;
  localparam int DEPTH = 16;
  localparam int DIVW  = 16;
  localparam int BW    = $clog2(DW+1);
  localparam int LW    = $clog2(DEPTH)+1;

  // Clock / reset ------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [BW-1:0]   cfg_bits;
  logic [1:0]      cfg_parity;
  logic            cfg_stop;
  logic [DIVW-1:0] cfg_div;
  logic            tx_serial;
  logic            tx_busy;
  logic            tx_done;
  logic [LW-1:0]   fifo_level;
  logic            fifo_empty;
  logic            fifo_full;
  uart_state_e     dbg_state;

  uart_tx_fifo_if #(.DATA_WIDTH(DW)) tx_if ();

  uart_tx_fifo #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .DIV_WIDTH  (DIVW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_if        (tx_if),
    .i_cfg_bits   (cfg_bits),
    .i_cfg_parity (cfg_parity),
    .i_cfg_stop   (cfg_stop),
    .i_cfg_div    (cfg_div),
    .o_tx_serial  (tx_serial),
    .o_tx_busy    (tx_busy),
    .o_tx_done    (tx_done),
    .o_fifo_level (fifo_level),
    .o_fifo_empty (fifo_empty),
    .o_fifo_full  (fifo_full),
    .o_state      (dbg_state)
  );

  // Scoreboard -----------------------------------------------------------
  int         checks   = 0;
  int         failures = 0;
  logic [2:0] exp_q[$];   // {busy, done, serial} per cycle
  logic [2:0] obs_q[$];
  bit         rec_on    = 1'b0;
  bit         pend_done = 1'b0;

  always @(negedge clk) begin
    if (rec_on) obs_q.push_back({tx_busy, tx_done, tx_serial});
  end

  task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model -------------------------------------------------------
  task automatic model_idle(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({1'b0, pend_done, 1'b1});
      pend_done = 1'b0;
    end
  endtask

  task automatic model_frame(input logic [DW-1:0] d, input int bits, input int par,
                             input int stop, input int div);
    int   n;
    logic p;
    logic line[$];
    n = (bits < 5) ? 5 : ((bits > DW) ? DW : bits);
    p = 1'b0;
    line.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      line.push_back(d[i]);
      p = p ^ d[i];
    end
    if (par == 1) line.push_back(p);
    else if (par == 2) line.push_back(~p);
    line.push_back(1'b1);
    if (stop != 0) line.push_back(1'b1);
    foreach (line[k]) begin
      for (int c = 0; c <= div; c++) begin
        exp_q.push_back({1'b1, pend_done, line[k]});
        pend_done = 1'b0;
      end
    end
    pend_done = 1'b1;
  endtask

  function automatic int count_busy();
    int n = 0;
    foreach (obs_q[i]) if (obs_q[i][2]) n++;
    return n;
  endfunction

  function automatic int count_done();
    int n = 0;
    foreach (obs_q[i]) if (obs_q[i][1]) n++;
    return n;
  endfunction

  // Driver tasks ----------------------------------------------------------
  task automatic set_cfg(input int bits, input int par, input int stop, input int div);
    @(negedge clk);
    cfg_bits   = BW'(bits);
    cfg_parity = 2'(par);
    cfg_stop   = 1'(stop);
    cfg_div    = DIVW'(div);
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    @(negedge clk);
    tx_if.i_tx_valid = 1'b1;
    tx_if.i_tx_data  = d;
    @(posedge clk);
    #1;
    tx_if.i_tx_valid = 1'b0;
  endtask

  task automatic start_stream();
    obs_q.delete();
    exp_q.delete();
    pend_done = 1'b0;
    model_idle(1);   // the cycle between the push edge and the pop edge
  endtask

  // Waits (bounded) until the recorder has as many samples as the model,
  // then reports the first differing sample, or the last one if all agree.
  task automatic check_stream(input string tag);
    int lim;
    int n;
    int idx;
    bit found;
    lim = exp_q.size() + 200;
    for (int c = 0; c < lim && obs_q.size() < exp_q.size(); c++) begin
      @(negedge clk);
      #1;
    end
    rec_on = 1'b0;
    check1({tag, "_len"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    if (n > 0) begin
      idx   = n - 1;
      found = 1'b0;
      for (int i = 0; i < n; i++) begin
        if (!found && obs_q[i] !== exp_q[i]) begin
          idx   = i;
          found = 1'b1;
        end
      end
      checks++;
      assert (obs_q[idx] === exp_q[idx]) else begin
        failures++;
        $error("FAIL %s_stream sample=%0d observed=%b expected=%b (busy,done,serial)",
               tag, idx, obs_q[idx], exp_q[idx]);
      end
    end
  endtask

  // Stimulus --------------------------------------------------------------
  logic [DW-1:0] words[$];
  logic [DW-1:0] w0, w1;

  initial begin
    rst_n            = 1'b0;
    tx_if.i_tx_valid = 1'b0;
    tx_if.i_tx_data  = '0;
    cfg_bits         = BW'(8);
    cfg_parity       = 2'b00;
    cfg_stop         = 1'b0;
    cfg_div          = DIVW'(3);

    // Reset state
    repeat (3) @(negedge clk);
    check1("rst_serial", tx_serial, 1);
    check1("rst_busy", tx_busy, 0);
    check1("rst_done", tx_done, 0);
    check1("rst_level", fifo_level, 0);
    check1("rst_empty", fifo_empty, 1);
    check1("rst_full", fifo_full, 0);
    check1("rst_ready", tx_if.o_tx_ready, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 basic
    set_cfg(8, 0, 0, 3);
    start_stream();
    push_word(9'h0A5);
    rec_on = 1'b1;
    model_frame(9'h0A5, 8, 0, 0, 3);
    model_idle(3);
    check_stream("8n1");
    check1("8n1_frame_clocks", count_busy(), 40);
    check1("8n1_done_pulses", count_done(), 1);
    check1("8n1_start_latency", obs_q[1][0], 0);

    // 7-bit, even parity, two stop bits
    set_cfg(7, 1, 1, 3);
    start_stream();
    push_word(9'h055);
    rec_on = 1'b1;
    model_frame(9'h055, 7, 1, 1, 3);
    model_idle(3);
    check_stream("7e2");
    check1("7e2_frame_clocks", count_busy(), 44);
    check1("7e2_parity_bit", obs_q[33][0], 0);

    // 7-bit, odd parity, two stop bits
    set_cfg(7, 2, 1, 3);
    start_stream();
    push_word(9'h055);
    rec_on = 1'b1;
    model_frame(9'h055, 7, 2, 1, 3);
    model_idle(3);
    check_stream("7o2");
    check1("7o2_parity_bit", obs_q[33][0], 1);

    // Mid-frame divisor change affects only the next frame
    set_cfg(8, 0, 0, 3);
    w0 = DW'($urandom);
    w1 = DW'($urandom);
    start_stream();
    push_word(w0);
    rec_on = 1'b1;
    push_word(w1);
    repeat (15) @(negedge clk);
    cfg_div = DIVW'(7);
    model_frame(w0, 8, 0, 0, 3);
    model_frame(w1, 8, 0, 0, 7);
    model_idle(3);
    check_stream("cfg_change");
    check1("cfg_change_busy_clocks", count_busy(), 40 + 80);

    // Clamp to 5 bits with one-clock bits
    set_cfg(2, 0, 0, 0);
    w0 = DW'($urandom);
    start_stream();
    push_word(w0);
    rec_on = 1'b1;
    model_frame(w0, 2, 0, 0, 0);
    model_idle(3);
    check_stream("clamp");
    check1("clamp_frame_clocks", count_busy(), 7);

    // Back-to-back and full: one frame in flight plus 16 queued, then refusal
    set_cfg(8, 0, 0, 100);
    words.delete();
    for (int i = 0; i < 17; i++) words.push_back(DW'($urandom));
    start_stream();
    push_word(words[0]);
    rec_on = 1'b1;
    for (int i = 1; i < 17; i++) push_word(words[i]);
    @(negedge clk);
    check1("full_ready", tx_if.o_tx_ready, 0);
    check1("full_flag", fifo_full, 1);
    check1("full_level", fifo_level, 16);
    push_word(9'h1FF);
    @(negedge clk);
    check1("full_level_after_refused", fifo_level, 16);
    foreach (words[i]) model_frame(words[i], 8, 0, 0, 100);
    model_idle(3);
    check_stream("b2b");
    check1("b2b_done_pulses", count_done(), 17);
    check1("b2b_no_gap_busy_clocks", count_busy(), 17 * 10 * 101);

    // Reset during PARITY with three words queued
    set_cfg(8, 1, 0, 3);
    push_word(9'h003);
    for (int i = 0; i < 3; i++) push_word(DW'($urandom));
    for (int c = 0; c < 300 && dbg_state != PARITY; c++) @(negedge clk);
    check1("rst_mid_reached_parity", (dbg_state == PARITY), 1);
    check1("rst_mid_parity_bit", tx_serial, 0);
    check1("rst_mid_level_before", fifo_level, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check1("rst_mid_serial", tx_serial, 1);
    check1("rst_mid_level", fifo_level, 0);
    check1("rst_mid_busy", tx_busy, 0);
    check1("rst_mid_empty", fifo_empty, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_stream();
    rec_on = 1'b1;
    model_idle(39);
    check_stream("post_reset_idle");

    // Randomized batches
    for (int b = 0; b < 6; b++) begin
      int rb, rp, rs, rd, n;
      rb = $urandom_range(0, 15);
      rp = $urandom_range(0, 3);
      rs = $urandom_range(0, 1);
      rd = $urandom_range(0, 4);
      n  = $urandom_range(1, 6);
      set_cfg(rb, rp, rs, rd);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back(DW'($urandom));
      start_stream();
      push_word(words[0]);
      rec_on = 1'b1;
      for (int i = 1; i < n; i++) push_word(words[i]);
      foreach (words[i]) model_frame(words[i], rb, rp, rs, rd);
      model_idle(3);
      check_stream($sformatf("rand%0d", b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
